rom2ram_loader: RTL and testbench
=================================

Name: rom2ram_loader

Overview:
- Boot-time copier: streams ROM images from the external SPI configuration flash into the SRAM ROM region (VA[18:13]=00xxxx).
- Drives the memory controller's rom2ram_ram_address / rom2ram_ram_wren / rom2ram_dataout inputs, which take priority over the CPU and video on the VA/VD bus.
- Holds `active` high while copying; top level keeps the CPU in reset until `done`.

Parameters:
- FLASH_BASE, 24'h0B0000, flash byte address of the first ROM byte.
- LENGTH, 17'h1C000, bytes to copy (112 KB); legal range 1..2^17-1.
- SCK_HALF, 2, clk28 cycles per SPI SCK half-period (min 1; default 7 MHz).
- WR_PULSE, 3, clk28 cycles rom2ram_ram_wren is held high per byte (min 1).

Ports:
- clk28  in  1  system clock, 28 MHz
- rst  in  1  asynchronous reset, active-high
- spi_cs_n  out  1  flash chip select, active-low
- spi_sck  out  1  flash clock, SPI mode 0
- spi_mosi  out  1  flash serial data in
- spi_miso  in  1  flash serial data out
- rom2ram_ram_address  out  17  SRAM byte offset within the ROM region
- rom2ram_ram_wren  out  1  SRAM write strobe to the memory controller
- rom2ram_dataout  out  8  byte to write
- active  out  1  copy in progress
- done  out  1  copy finished, sticky until reset

Behaviour:
- Reset values (asynchronous, all outputs): spi_cs_n=1, spi_sck=0, spi_mosi=0, rom2ram_ram_address=0, rom2ram_ram_wren=0, rom2ram_dataout=0, active=1, done=0.
- `active` is 1 from reset so the CPU never runs before the copy. `active` = NOT `done` at all times.
- State machine: START -> CMD -> DATA -> WSETUP -> WPULSE -> WHOLD -> (DATA | FINISH).
- START:
  - Lasts one cycle after reset release.
  - Drives cs_n=0, loads the 32-bit shift register with {8'h03, FLASH_BASE}, clears the byte counter.
- CMD:
  - Shifts 32 bits MSB first.
  - mosi changes while sck=0. sck toggles every SCK_HALF cycles.
  - Each bit is one low half-period followed by one high half-period.
  - After the 32nd high half, sck returns low and the FSM goes to DATA.
- DATA:
  - 8 bits, MSB first. miso is sampled on the clk28 cycle in which sck rises. mosi=0.
  - After 8 bits, sck=0, the byte is latched into rom2ram_dataout, and the FSM goes to WSETUP.
- WSETUP (1 cycle):
  - Address and data are stable; wren=0.
  - This gives the memory controller setup time, since it muxes VA combinationally on wren.
- WPULSE: wren=1 for exactly WR_PULSE cycles.
- WHOLD (1 cycle):
  - wren=0; address and data are unchanged.
  - Then the byte counter and address increment. Address is 17-bit, no wrap within legal LENGTH.
  - If counter == LENGTH go to FINISH, else go to DATA.
- During WSETUP/WPULSE/WHOLD: sck is held low and cs_n stays low. The flash read stream resumes on the next sck edge, so no new command is issued.
- FINISH (terminal): cs_n=1, sck=0, wren=0, done=1, active=0. Address stays at LENGTH. Only reset leaves FINISH.
- Ordering: bytes land at address 0..LENGTH-1 in flash order. Each address gets exactly one wren pulse.
- rom2ram_dataout and rom2ram_ram_address change only in DATA->WSETUP or WHOLD, never while wren=1.
- Reset mid-operation (any state): outputs return to reset values immediately and cs_n deasserts asynchronously. The copy restarts from FLASH_BASE / address 0 after release.
- Per-byte time: 8·2·SCK_HALF + WR_PULSE + 2 cycles. Defaults give 37 cycles.

Optional Feature:
- Macro ROM2RAM_CHECKSUM_EN.
- When defined, adds parameter EXPECTED_SUM (16 bits, default 16'h0000) and output port checksum_ok (1 bit, reset 0).
  - A 16-bit accumulator is cleared in START and adds each byte, zero-extended, in WHOLD. Overflow wraps mod 2^16.
  - checksum_ok is set together with done when accumulator == EXPECTED_SUM, else stays 0.
  - The accumulator is internal only.
- When undefined: no accumulator, no port, no parameter. Behaviour is otherwise identical.

Test Plan:
- Flash model holds 8'hA5,8'h3C,8'hFF,8'h00 at FLASH_BASE; LENGTH=4, SCK_HALF=1, WR_PULSE=2 -> MOSI carries 03 0B 00 00; four wren pulses of 2 cycles at addresses 0..3 with data A5,3C,FF,00; done=1 after the 4th WHOLD; cs_n=1.
- Same setup, check every wren pulse -> address and data are stable 1 cycle before the rising edge and 1 cycle after the falling edge; sck=0 throughout each write.
- Reset asserted during the 2nd DATA byte -> cs_n=1, wren=0, active=1, done=0 in the same cycle; after release the command is reissued and address restarts at 0.
- LENGTH=1, SCK_HALF=3 -> sck high/low phases are each exactly 3 cycles; one write at address 0; done=1; remains in FINISH for 1000 cycles with no sck activity.
- ROM2RAM_CHECKSUM_EN, bytes 01,02,03,04, EXPECTED_SUM=16'h000A -> checksum_ok=1 together with done. With EXPECTED_SUM=16'h000B -> checksum_ok=0 and done=1.
- LENGTH=3 with all bytes FF, ROM2RAM_CHECKSUM_EN, EXPECTED_SUM=16'h02FD -> checksum_ok=1 (confirms zero-extended accumulation).

Source files
------------

// File: rtl/rom2ram_loader.sv
// rom2ram_loader: boot-time copier from SPI flash into the SRAM ROM region.
// Define ROM2RAM_CHECKSUM_EN to add EXPECTED_SUM and the checksum_ok output.
module rom2ram_loader #(
  parameter logic [23:0] FLASH_BASE = 24'h0B0000,
  parameter logic [16:0] LENGTH = 17'h1C000,
  parameter int SCK_HALF = 2,
  parameter int WR_PULSE = 3
`ifdef ROM2RAM_CHECKSUM_EN
  , parameter logic [15:0] EXPECTED_SUM = 16'h0000
`endif
) (
  input  logic clk28,
  input  logic rst,
  output logic spi_cs_n,
  output logic spi_sck,
  output logic spi_mosi,
  input  logic spi_miso,
  output logic [16:0] rom2ram_ram_address,
  output logic rom2ram_ram_wren,
  output logic [7:0] rom2ram_dataout,
  output logic active,
  output logic done
`ifdef ROM2RAM_CHECKSUM_EN
  , output logic checksum_ok
`endif
);
  typedef enum logic [2:0] {START, CMD, DATA, WSETUP, WPULSE, WHOLD, FINISH} state_t;
  localparam logic [31:0] CMD_WORD = {8'h03, FLASH_BASE};
  localparam logic [15:0] HALF_LAST = 16'(SCK_HALF - 1);
  localparam logic [15:0] PULSE_LAST = 16'(WR_PULSE - 1);
  state_t state;
  logic [31:0] sr;
  logic [15:0] tick;
  logic [4:0] bit_cnt;
  logic half_end, last_bit;
  assign half_end = tick == HALF_LAST;
  assign last_bit = bit_cnt == (state == CMD ? 5'd31 : 5'd7);
`ifdef ROM2RAM_CHECKSUM_EN
  logic [15:0] acc, acc_next;
  assign acc_next = acc + {8'h00, rom2ram_dataout};
`endif
  always_ff @(posedge clk28 or posedge rst)
    if (rst) begin
      state <= START;
      sr <= '0;
      tick <= '0;
      bit_cnt <= '0;
      spi_cs_n <= 1'b1;
      spi_sck <= 1'b0;
      spi_mosi <= 1'b0;
      rom2ram_ram_address <= '0;
      rom2ram_ram_wren <= 1'b0;
      rom2ram_dataout <= '0;
      active <= 1'b1;
      done <= 1'b0;
`ifdef ROM2RAM_CHECKSUM_EN
      acc <= '0;
      checksum_ok <= 1'b0;
`endif
    end else begin
      case (state)
        START: begin
          spi_cs_n <= 1'b0;
          spi_mosi <= CMD_WORD[31];
          sr <= {CMD_WORD[30:0], 1'b0};
          rom2ram_ram_address <= '0;
          tick <= '0;
          bit_cnt <= '0;
`ifdef ROM2RAM_CHECKSUM_EN
          acc <= '0;
`endif
          state <= CMD;
        end
        CMD, DATA: begin
          tick <= half_end ? '0 : tick + 16'd1;
          if (half_end) begin
            spi_sck <= ~spi_sck;
            if (!spi_sck && state == DATA) sr <= {sr[30:0], spi_miso};
            // falling edge ends a bit: advance mosi during the command, finish the byte during data
            if (spi_sck) begin
              bit_cnt <= last_bit ? 5'd0 : bit_cnt + 5'd1;
              if (state == CMD) {spi_mosi, sr} <= last_bit ? 33'd0 : {sr, 1'b0};
              if (last_bit && state == DATA) rom2ram_dataout <= sr[7:0];
              if (last_bit) state <= state == CMD ? DATA : WSETUP;
            end
          end
        end
        WSETUP: begin
          rom2ram_ram_wren <= 1'b1;
          tick <= '0;
          state <= WPULSE;
        end
        WPULSE: begin
          tick <= tick == PULSE_LAST ? '0 : tick + 16'd1;
          if (tick == PULSE_LAST) begin
            rom2ram_ram_wren <= 1'b0;
            state <= WHOLD;
          end
        end
        WHOLD: begin
          rom2ram_ram_address <= rom2ram_ram_address + 17'd1;
`ifdef ROM2RAM_CHECKSUM_EN
          acc <= acc_next;
          if (rom2ram_ram_address == LENGTH - 17'd1) checksum_ok <= acc_next == EXPECTED_SUM;
`endif
          if (rom2ram_ram_address == LENGTH - 17'd1) begin
            spi_cs_n <= 1'b1;
            done <= 1'b1;
            active <= 1'b0;
            state <= FINISH;
          end else
            state <= DATA;
        end
        FINISH: state <= FINISH;
        default: state <= START;
      endcase
    end
endmodule

// File: tb/tb_rom2ram_loader.sv
// tb_rom2ram_loader: two loader instances (fast 4-byte copy, slow 1-byte copy) against SPI flash models.
`timescale 1ns/1ps
module tb_rom2ram_loader;
  localparam logic [31:0] CMD_EXP = 32'h030B0000;
  localparam int WP_A = 2;
  logic clk28 = 1'b0;
  always #5 clk28 = ~clk28;
  logic rst_a, rst_b;
  logic cs_a, sck_a, mosi_a, wren_a, active_a, done_a;
  logic cs_b, sck_b, mosi_b, wren_b, active_b, done_b;
  logic miso_a = 1'b0, miso_b = 1'b0;
  logic [16:0] addr_a, addr_b;
  logic [7:0] data_a, data_b;
`ifdef ROM2RAM_CHECKSUM_EN
  logic ok_a, ok_b;
`endif

  rom2ram_loader #(.LENGTH(17'd4), .SCK_HALF(1), .WR_PULSE(WP_A)
`ifdef ROM2RAM_CHECKSUM_EN
    , .EXPECTED_SUM(16'h000A)
`endif
  ) dut_a (
    .clk28(clk28), .rst(rst_a), .spi_cs_n(cs_a), .spi_sck(sck_a), .spi_mosi(mosi_a),
    .spi_miso(miso_a), .rom2ram_ram_address(addr_a), .rom2ram_ram_wren(wren_a),
    .rom2ram_dataout(data_a), .active(active_a), .done(done_a)
`ifdef ROM2RAM_CHECKSUM_EN
    , .checksum_ok(ok_a)
`endif
  );

  rom2ram_loader #(.LENGTH(17'd1), .SCK_HALF(3), .WR_PULSE(3)) dut_b (
    .clk28(clk28), .rst(rst_b), .spi_cs_n(cs_b), .spi_sck(sck_b), .spi_mosi(mosi_b),
    .spi_miso(miso_b), .rom2ram_ram_address(addr_b), .rom2ram_ram_wren(wren_b),
    .rom2ram_dataout(data_b), .active(active_b), .done(done_b)
`ifdef ROM2RAM_CHECKSUM_EN
    , .checksum_ok(ok_b)
`endif
  );

  // Flash models: capture the command on sck rise, shift the image out on sck fall (mode 0)
  logic [31:0] img_a = '0, cmd_a = '0, cmd_b = '0;
  logic [7:0] img_b = '0;
  int rises_a = 0, rises_b = 0;
  always @(posedge sck_a or negedge cs_a)
    if (sck_a) begin
      if (rises_a < 32) cmd_a = {cmd_a[30:0], mosi_a};
      rises_a++;
    end else begin
      rises_a = 0;
      cmd_a = '0;
    end
  always @(negedge sck_a) begin
    int k;
    k = rises_a - 32;
    miso_a = (!cs_a && cmd_a == CMD_EXP && k >= 0 && k < 32) ? img_a[31-k] : 1'b0;
  end
  always @(posedge sck_b or negedge cs_b)
    if (sck_b) begin
      if (rises_b < 32) cmd_b = {cmd_b[30:0], mosi_b};
      rises_b++;
    end else begin
      rises_b = 0;
      cmd_b = '0;
    end
  always @(negedge sck_b) begin
    int k;
    k = rises_b - 32;
    miso_b = (!cs_b && cmd_b == CMD_EXP && k >= 0 && k < 8) ? img_b[7-k] : 1'b0;
  end

  int total = 0, bad = 0;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: sum of zero-extended bytes of an image, first byte in the top bits
  function automatic logic [15:0] sum_bytes(input logic [31:0] w, input int n);
    logic [15:0] s;
    s = '0;
    for (int i = 0; i < n; i++) s += {8'h00, w[31-8*i -: 8]};
    return s;
  endfunction

  logic pw_a = 1'b0, pw_b = 1'b0, ps_b = 1'b0;
  logic [16:0] pa_a = '0, wa_b = '0;
  logic [7:0] pd_a = '0, wd_b = '0;
  int plen_a = 0, run_b = 0, toggles_b = 0, nwr_b = 0;
  logic [24:0] wq_a[$];

  task automatic mon_a();
    if (rst_a) begin
      wq_a.delete();
      plen_a = 0;
    end else if (wren_a) begin
      if (!pw_a) begin
        chk("setup_addr", addr_a, pa_a);
        chk("setup_data", data_a, pd_a);
        wq_a.push_back({addr_a, data_a});
        plen_a = 0;
      end else begin
        chk("pulse_addr", addr_a, pa_a);
        chk("pulse_data", data_a, pd_a);
      end
      plen_a++;
      chk("wr_sck_low", sck_a, 0);
      chk("wr_cs_low", cs_a, 0);
    end else if (pw_a) begin
      chk("pulse_len", plen_a, WP_A);
      chk("hold_addr", addr_a, pa_a);
      chk("hold_data", data_a, pd_a);
      chk("hold_sck_low", sck_a, 0);
    end
    pw_a = wren_a;
    pa_a = addr_a;
    pd_a = data_a;
  endtask

  task automatic mon_b();
    if (rst_b || cs_b) run_b = 0;
    else if (sck_b != ps_b) begin
      if (run_b > 0 && sck_b) chk("sck_low_len", run_b, 3);
      if (run_b > 0 && !sck_b) chk("sck_high_len", run_b, 3);
      run_b = 1;
    end else run_b++;
    if (sck_b != ps_b) toggles_b++;
    if (rst_b) nwr_b = 0;
    else if (wren_b && !pw_b) begin
      nwr_b++;
      wa_b = addr_b;
      wd_b = data_b;
    end
    ps_b = sck_b;
    pw_b = wren_b;
  endtask

  task automatic tick();
    @(negedge clk28);
    mon_a();
    mon_b();
  endtask

  task automatic wait_done_a();
    for (int c = 0; c < 2000 && !done_a; c++) tick();
    chk("done_a", done_a, 1);
  endtask

  task automatic check_a(input logic [31:0] img, input logic [15:0] sum);
    logic [15:0] s;
    s = '0;
    chk("wr_count", wq_a.size(), 4);
    for (int i = 0; i < 4; i++)
      if (i < wq_a.size()) begin
        s += {8'h00, wq_a[i][7:0]};
        chk("wr_addr", wq_a[i][24:8], i);
        chk("wr_data", wq_a[i][7:0], img[31-8*i -: 8]);
      end
    chk("written_sum", s, sum);
    chk("cmd_a", cmd_a, CMD_EXP);
    chk("fin_cs_n", cs_a, 1);
    chk("fin_sck", sck_a, 0);
    chk("fin_wren", wren_a, 0);
    chk("fin_active", active_a, 0);
    chk("fin_addr", addr_a, 4);
`ifdef ROM2RAM_CHECKSUM_EN
    chk("checksum_ok_a", ok_a, sum == 16'h000A);
`endif
  endtask

  typedef struct { logic [31:0] img; logic [15:0] sum; } vec_t;
  vec_t vecs[8];

  initial begin
    vecs[0] = '{32'hA53CFF00, 16'h01E0};
    vecs[1] = '{32'h01020304, 16'h000A};
    vecs[2] = '{32'h01020305, 16'h000B};
    vecs[3] = '{32'hFFFF0C00, 16'h020A};
    vecs[4] = '{32'hFFFFFFFF, 16'h03FC};
    for (int i = 5; i < 8; i++) begin
      vecs[i].img = $urandom;
      vecs[i].sum = sum_bytes(vecs[i].img, 4);
    end
    rst_a = 1'b1;
    rst_b = 1'b1;
    tick();
    tick();
    chk("rst_cs_n", cs_a, 1);
    chk("rst_sck", sck_a, 0);
    chk("rst_mosi", mosi_a, 0);
    chk("rst_addr", addr_a, 0);
    chk("rst_wren", wren_a, 0);
    chk("rst_data", data_a, 0);
    chk("rst_active", active_a, 1);
    chk("rst_done", done_a, 0);
`ifdef ROM2RAM_CHECKSUM_EN
    chk("rst_checksum_ok", ok_a, 0);
`endif
    for (int i = 0; i < 8; i++) begin
      img_a = vecs[i].img;
      rst_a = 1'b1;
      tick();
      tick();
      rst_a = 1'b0;
      wait_done_a();
      check_a(vecs[i].img, vecs[i].sum);
    end
    // Reset while the second byte is being read, then a full restart
    img_a = 32'hA53CFF00;
    rst_a = 1'b1;
    tick();
    rst_a = 1'b0;
    for (int c = 0; c < 2000 && addr_a != 17'd1; c++) tick();
    repeat (5) tick();
    chk("mid_addr", addr_a, 1);
    chk("mid_cs_n", cs_a, 0);
    #2 rst_a = 1'b1;
    #1;
    chk("mid_rst_cs_n", cs_a, 1);
    chk("mid_rst_wren", wren_a, 0);
    chk("mid_rst_active", active_a, 1);
    chk("mid_rst_done", done_a, 0);
    chk("mid_rst_sck", sck_a, 0);
    chk("mid_rst_addr", addr_a, 0);
    tick();
    rst_a = 1'b0;
    wait_done_a();
    check_a(32'hA53CFF00, 16'h01E0);
    // Slow single-byte copy, then an idle FINISH
    img_b = 8'($urandom);
    rst_b = 1'b0;
    for (int c = 0; c < 3000 && !done_b; c++) tick();
    chk("done_b", done_b, 1);
    chk("cmd_b", cmd_b, CMD_EXP);
    chk("wr_count_b", nwr_b, 1);
    chk("wr_addr_b", wa_b, 0);
    chk("wr_data_b", wd_b, img_b);
    chk("fin_addr_b", addr_b, 1);
`ifdef ROM2RAM_CHECKSUM_EN
    chk("checksum_ok_b", ok_b, sum_bytes({img_b, 24'h0}, 1) == 16'h0000);
`endif
    toggles_b = 0;
    repeat (1000) tick();
    chk("idle_toggles_b", toggles_b, 0);
    chk("idle_cs_n_b", cs_b, 1);
    chk("idle_done_b", done_b, 1);
    chk("idle_active_b", active_b, 0);
    chk("idle_wren_b", wren_b, 0);
    chk("idle_wr_count_b", nwr_b, 1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
